// File: rtl/aria_round_ctrl_if.sv
// aria_round_ctrl_if: host request/result handshake between register interface and ARIA round controller
interface aria_round_ctrl_if;
  logic start, keyinit, abort, out_rdy, out_vld, busy, done, err;
  logic [1:0] ksize;
  modport master(output start, keyinit, ksize, abort, out_rdy, input out_vld, busy, done, err);
  modport slave(input start, keyinit, ksize, abort, out_rdy, output out_vld, busy, done, err);
endinterface

// File: rtl/aria_round_ctrl.sv
// aria_round_ctrl: sequences ARIA key-init steps and 12/14/16 data rounds off the round counter flags
module aria_round_ctrl (
  input  logic             clk,
  input  logic             rst,
  aria_round_ctrl_if.slave host,
  input  logic             flg_klast,
  input  logic             flg_rlast,
  input  logic             flg_ltinv,
  output logic [1:0]       st_ksize,
  output logic             nr_clr,
  output logic             nr_en,
  output logic             ld_in,
  output logic             key_en,
  output logic             rnd_en,
  output logic             sel_odd,
  output logic             sel_last
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, KINIT = 3'd2, ROUND = 3'd3, OUT = 3'd4;
  logic [2:0] state, nxt;
  logic mode_key, act, acc;
  assign act = ~host.abort;
  assign acc = act & (state == IDLE) & host.start & (host.ksize != 2'b00);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st_ksize <= 2'b00;
      mode_key <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        st_ksize <= host.ksize;
        mode_key <= host.keyinit;
      end
    end
  end
  always_comb begin
    nxt = host.abort ? IDLE :
          (state == IDLE)  ? (acc ? LOAD : IDLE) :
          (state == LOAD)  ? (mode_key ? KINIT : ROUND) :
          (state == KINIT) ? (flg_klast ? OUT : KINIT) :
          (state == ROUND) ? (flg_rlast ? OUT : ROUND) :
          (state == OUT)   ? (host.out_rdy ? IDLE : OUT) : IDLE;
  end
  always_comb begin
    nr_clr = host.abort | (state == IDLE) | (state == LOAD) |
             ((state == KINIT) & flg_klast) | ((state == ROUND) & flg_rlast);
    nr_en = act & (((state == KINIT) & ~flg_klast) | ((state == ROUND) & ~flg_rlast));
    ld_in = act & (state == LOAD);
    key_en = act & (state == KINIT);
    rnd_en = act & (state == ROUND);
    sel_odd = rnd_en & ~flg_ltinv;
    sel_last = rnd_en & flg_rlast;
    host.out_vld = act & (state == OUT);
    host.done = act & (state == OUT) & host.out_rdy;
    host.err = act & (state == IDLE) & host.start & (host.ksize == 2'b00);
    host.busy = state != IDLE;
  end
endmodule

// File: tb/tb_aria_round_ctrl.sv
// tb_aria_round_ctrl: timeline-model and directed-vector bench for aria_round_ctrl with a round counter model
module tb_aria_round_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flg_klast, flg_rlast, flg_ltinv;
  logic [1:0] st_ksize;
  logic nr_clr, nr_en, ld_in, key_en, rnd_en, sel_odd, sel_last;
  logic [3:0] nr;
  aria_round_ctrl_if h();
  aria_round_ctrl dut (
    .clk(clk), .rst(rst), .host(h),
    .flg_klast(flg_klast), .flg_rlast(flg_rlast), .flg_ltinv(flg_ltinv),
    .st_ksize(st_ksize), .nr_clr(nr_clr), .nr_en(nr_en), .ld_in(ld_in),
    .key_en(key_en), .rnd_en(rnd_en), .sel_odd(sel_odd), .sel_last(sel_last)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) nr <= (rst | nr_clr) ? 4'd0 : nr_en ? nr + 4'd1 : nr;
  assign flg_klast = nr == 4'd3;
  assign flg_rlast = nr == 4'(9 + 2 * int'(st_ksize));
  assign flg_ltinv = nr[0];
  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;
  bit chk_en = 1'b0;
  logic m_busy = 1'b0, m_key = 1'b0;
  logic [1:0] m_ks = 2'b00;
  int m_t = 0, m_n = 0;
  logic [31:0] ld_mask, key_mask, nren_mask, clr_mask, vld_mask, done_mask, err_mask, busy_mask, last_mask, rnd_mask;
  logic [15:0] odd_seq;
  int rnd_cnt, done_cnt, done_at;
  int nr_tr[32];
  int n_tab[3] = '{12, 14, 16};
  int done_tab[3] = '{14, 16, 18};
  logic [31:0] odd_tab[3] = '{32'h0AAA, 32'h2AAA, 32'hAAAA};
  logic [31:0] last_tab[3] = '{32'h2000, 32'h8000, 32'h20000};
  logic [31:0] busy_tab[3] = '{32'h7FFE, 32'h1FFFE, 32'h7FFFE};
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask
  function automatic logic [12:0] model_out();
    logic clr, en, ld, ke, re, so, sl, ov, dn, er;
    int last;
    {clr, en, ld, ke, re, so, sl, ov, dn, er} = '0;
    last = m_key ? 5 : 1 + m_n;
    if (!m_busy) begin
      clr = 1'b1;
      er = h.start && h.ksize == 2'b00;
    end else if (m_t == 1) begin
      ld = 1'b1;
      clr = 1'b1;
    end else if (m_t <= last) begin
      ke = m_key;
      re = !m_key;
      en = m_t < last;
      clr = m_t == last;
      so = !m_key && (m_t % 2 == 0);
      sl = !m_key && m_t == last;
    end else begin
      ov = 1'b1;
      dn = h.out_rdy;
    end
    if (h.abort) begin
      {en, ld, ke, re, so, sl, ov, dn, er} = '0;
      clr = 1'b1;
    end
    return {m_ks, clr, en, ld, ke, re, so, sl, ov, m_busy, dn, er};
  endfunction
  task automatic model_update();
    int last;
    last = m_key ? 5 : 1 + m_n;
    if (rst) begin
      m_busy = 1'b0;
      m_ks = 2'b00;
      m_key = 1'b0;
    end else if (h.abort) m_busy = 1'b0;
    else if (!m_busy) begin
      if (h.start && h.ksize != 2'b00) begin
        m_busy = 1'b1;
        m_t = 1;
        m_key = h.keyinit;
        m_ks = h.ksize;
        m_n = 10 + 2 * int'(h.ksize);
      end
    end else if (m_t > last && h.out_rdy) m_busy = 1'b0;
    else m_t++;
  endtask
  task automatic clr_trace();
    {ld_mask, key_mask, nren_mask, clr_mask, vld_mask, done_mask, err_mask, busy_mask, last_mask, rnd_mask} = '0;
    odd_seq = '0;
    rnd_cnt = 0;
    done_cnt = 0;
    done_at = -1;
    for (int i = 0; i < 32; i++) nr_tr[i] = -1;
    t0 = cyc;
  endtask
  task automatic step();
    logic [12:0] a;
    int rel;
    @(negedge clk);
    rel = cyc - t0;
    a = {st_ksize, nr_clr, nr_en, ld_in, key_en, rnd_en, sel_odd, sel_last, h.out_vld, h.busy, h.done, h.err};
    if (chk_en) check("cycle_outputs", 32'(a), 32'(model_out()));
    if (rel >= 0 && rel < 32) begin
      ld_mask[rel] = ld_in;
      key_mask[rel] = key_en;
      rnd_mask[rel] = rnd_en;
      nren_mask[rel] = nr_en;
      clr_mask[rel] = nr_clr;
      vld_mask[rel] = h.out_vld;
      done_mask[rel] = h.done;
      err_mask[rel] = h.err;
      busy_mask[rel] = h.busy;
      last_mask[rel] = sel_last;
      nr_tr[rel] = int'(nr);
    end
    if (rnd_en) begin
      rnd_cnt++;
      odd_seq = {odd_seq[14:0], sel_odd};
    end
    if (h.done) begin
      done_cnt++;
      if (done_at < 0) done_at = rel;
    end
    @(posedge clk);
    model_update();
    if (rst) chk_en = 1'b1;
    cyc++;
    #1;
  endtask
  task automatic run(input logic key, input logic [1:0] ks, input int abort_at, input int rdy_at, input int rst_at, input int len);
    clr_trace();
    for (int r = 0; r < len; r++) begin
      h.start = (r == 0) || (rdy_at > 0 && r >= 8 && r < rdy_at && r % 2 == 0);
      h.keyinit = (r == 0) ? key : ~key;
      h.ksize = (r == 0) ? ks : 2'b11;
      h.abort = r == abort_at;
      h.out_rdy = r >= rdy_at;
      rst = r == rst_at;
      step();
    end
    h.start = 1'b0;
    h.abort = 1'b0;
    rst = 1'b0;
  endtask
  initial begin
    h.start = 1'b0;
    h.keyinit = 1'b0;
    h.ksize = 2'b00;
    h.abort = 1'b0;
    h.out_rdy = 1'b0;
    clr_trace();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    clr_trace();
    repeat (5) step();
    check("rst_busy", busy_mask, 32'h0);
    check("rst_nr_clr", clr_mask, 32'h1F);
    check("rst_st_ksize", 32'(st_ksize), 32'h0);
    check("rst_strobes", ld_mask | key_mask | rnd_mask | nren_mask | vld_mask | done_mask | err_mask, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      run(1'b0, 2'(k), -1, 0, -1, n_tab[k-1] + 4);
      check("data_rnd_cnt", 32'(rnd_cnt), 32'(n_tab[k-1]));
      check("data_sel_odd_seq", 32'(odd_seq), odd_tab[k-1]);
      check("data_sel_last_at", last_mask, last_tab[k-1]);
      check("data_done_at", 32'(done_at), 32'(done_tab[k-1]));
      check("data_busy_span", busy_mask, busy_tab[k-1]);
    end
    run(1'b1, 2'b11, -1, 0, -1, 8);
    check("key_ld_in", ld_mask, 32'h2);
    check("key_key_en", key_mask, 32'h3C);
    check("key_nr_en", nren_mask, 32'h1C);
    check("key_nr_clr", clr_mask, 32'hA3);
    check("key_out_vld", vld_mask, 32'h40);
    check("key_done", done_mask, 32'h40);
    check("key_no_rnd", rnd_mask, 32'h0);
    run(1'b0, 2'b00, -1, 0, -1, 3);
    check("illegal_err", err_mask, 32'h1);
    check("illegal_busy", busy_mask, 32'h0);
    check("illegal_st_ksize", 32'(st_ksize), 32'h3);
    run(1'b0, 2'b00, 0, 0, -1, 2);
    check("illegal_abort_err", err_mask, 32'h0);
    run(1'b0, 2'b01, 6, 0, -1, 8);
    check("abort_busy", busy_mask, 32'h7E);
    check("abort_nr_at_round5", 32'(nr_tr[6]), 32'h4);
    check("abort_nr_cleared", 32'(nr_tr[7]), 32'h0);
    run(1'b0, 2'b01, -1, 0, -1, 16);
    check("after_abort_nr0", 32'(nr_tr[2]), 32'h0);
    check("after_abort_rnd_cnt", 32'(rnd_cnt), 32'd12);
    check("after_abort_done_at", 32'(done_at), 32'd14);
    run(1'b1, 2'b01, -1, 13, -1, 16);
    check("hold_out_vld", vld_mask, 32'h3FC0);
    check("hold_done", done_mask, 32'h2000);
    check("hold_done_cnt", 32'(done_cnt), 32'd1);
    check("hold_busy", busy_mask, 32'h3FFE);
    check("hold_st_ksize", 32'(st_ksize), 32'h1);
    run(1'b0, 2'b10, -1, 0, 4, 7);
    check("midrst_busy", busy_mask, 32'h1E);
    check("midrst_st_ksize", 32'(st_ksize), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aria_round_ctrl.md
# aria_round_ctrl

Round-sequencing controller for the ARIA 1.1 core. It drives the round counter's `nr_clr`/`nr_en`/`st_ksize` inputs and consumes its `flg_klast`/`flg_rlast`/`flg_ltinv` flags. From these it generates per-cycle datapath strobes for key initialisation (4 steps) and for the 12/14/16-round data transform, then presents the result with a valid/ready handshake. It sits between the host-side register interface and the round datapath/key-schedule logic.

## Interface
No parameters.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset (tie counter `rst_n` to `~rst` at integration).
- `start` in 1: request; sampled only in IDLE.
- `keyinit` in 1: sampled with `start`; 1 = key initialisation, 0 = data block.
- `ksize` in 2: sampled with `start`; 01 = 128, 10 = 192, 11 = 256, 00 = illegal.
- `abort` in 1: return to IDLE from any state.
- `out_rdy` in 1: downstream accepts result.
- `flg_klast` in 1: counter flag, nr==3.
- `flg_rlast` in 1: counter flag, last round for `st_ksize`.
- `flg_ltinv` in 1: counter flag, nr[0].
- `st_ksize` out 2: registered key size to counter; reset 00.
- `nr_clr` out 1: counter clear.
- `nr_en` out 1: counter increment.
- `ld_in` out 1: load input block/key into datapath.
- `key_en` out 1: key-init step strobe.
- `rnd_en` out 1: round step strobe.
- `sel_odd` out 1: odd-type substitution layer, = ~`flg_ltinv` while `rnd_en`, else 0.
- `sel_last` out 1: final round (no diffusion, final whitening).
- `out_vld` out 1: result valid.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse on result handshake.
- `err` out 1: one-cycle pulse on illegal `ksize`.

## Operation
- State register: IDLE, LOAD, KINIT, ROUND, OUT. Mode bit `mode_key` and `st_ksize` are registered on accepted `start`.
- All strobes are combinational decodes of state and inputs. Every output not listed for a state is 0.
- **IDLE**: `nr_clr`=1.
  - `start` with `ksize`=00 → `err`=1 this cycle; stay IDLE; `st_ksize` unchanged.
  - `start` with legal `ksize` → latch `ksize`/`keyinit`; go to LOAD.
- **LOAD**: `ld_in`=1, `nr_clr`=1. Next state is KINIT if `mode_key`, else ROUND.
- **KINIT**: `key_en`=1.
  - `flg_klast`=0 → `nr_en`=1; stay.
  - `flg_klast`=1 → `nr_clr`=1, `nr_en`=0; go to OUT.
  - Exactly 4 `key_en` cycles (nr 0..3).
- **ROUND**: `rnd_en`=1, `sel_odd`=~`flg_ltinv`.
  - `flg_rlast`=0 → `nr_en`=1; stay.
  - `flg_rlast`=1 → `sel_last`=1, `nr_clr`=1; go to OUT.
  - Round counts: 12 (nr 0..11), 14, or 16 `rnd_en` cycles for ksize 01/10/11. Round 1 (nr=0) is odd type; odd and even alternate.
- **OUT**: `out_vld`=1, held until `out_rdy`. On `out_vld & out_rdy` → `done`=1; go to IDLE.
- `abort`=1 in any state: next state IDLE, `nr_clr`=1, all strobes and `done` forced 0 that cycle. `abort` beats `start` in IDLE; no `err` when aborted.
- `start` outside IDLE is ignored; no queuing.
- `nr_clr` and `nr_en` are never both 1.

## Timing
- Reset: state IDLE, `st_ksize`=00, `mode_key`=0. Outputs after reset: `nr_clr`=1, `busy`=0, all others 0.
- `start` accepted in cycle 0 → LOAD in cycle 1.
  - Data: ROUND cycles 2..(1+N), with N = 12/14/16. `out_vld` first asserts in cycle 2+N (14/16/18).
  - Key: KINIT cycles 2..5; `out_vld` in cycle 6.
- With `out_rdy` held high: `done` in the first OUT cycle; IDLE the next cycle. A new `start` can be accepted in that IDLE cycle.
- `out_rdy` low: OUT holds indefinitely. Counter stays at 0 (cleared on exit of KINIT/ROUND).
- `rst` mid-operation: IDLE the next cycle, same as the reset values above.

## Test plan
- Reset, then idle 5 cycles → `busy`=0, `nr_clr`=1, `st_ksize`=00, all strobes 0.
- Data, ksize=01, `out_rdy`=1:
  - 12 `rnd_en` cycles; `sel_odd` pattern 1,0,1,…,0.
  - `sel_last` only in the 12th.
  - `out_vld`+`done` in cycle 14; IDLE in cycle 15.
  - Repeat with ksize 10/11 → 14/16 rounds, `done` in cycle 16/18.
- Key init, ksize=11 → `ld_in` in cycle 1, `key_en` in cycles 2..5, `nr_en` in cycles 2..4, `nr_clr` in cycle 5, `out_vld` in cycle 6.
- `start` with ksize=00 → `err` 1-cycle pulse, `busy` stays 0, `st_ksize` unchanged. Same cycle with `abort`=1 → no `err`.
- `abort` at round 5 (ksize=01) → IDLE next cycle, counter cleared. Following `start` runs a full 12 rounds from nr=0.
- `out_rdy` held low 7 cycles in OUT → `out_vld` stays 1 and `done`=0. `start` pulses during OUT are ignored. `out_rdy`=1 → single `done`, then IDLE.
